elevator: RTL and testbench
===========================

ELEVATOR -- requirements
Module: elevator

Interface
REQ-001 Parameter MOVE_CYCLES, default 1: clock cycles spent travelling one floor (>=1).
REQ-002 Parameter DOOR_CYCLES, default 2: clock cycles the door stays open per stop (>=1).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 buttons  input  5  floor request buttons, bit i = floor i (0..4), level-sampled each clock edge.
REQ-006 floor  output  3  current floor, 0..4, registered.
REQ-007 dir_up  output  1  current/last travel direction, 1 = up.
REQ-008 moving  output  1  high in MOVE_UP or MOVE_DOWN.
REQ-009 door_open  output  1  high in DOOR_OPEN.
REQ-010 pending  output  5  registered outstanding requests.
REQ-011 Positional port order SHALL be buttons, clk, rst_n, floor, dir_up, moving, door_open, pending.

Function
REQ-012 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs registered.
REQ-013 Request latch: each edge, pending[i] <= pending[i] | buttons[i], except a bit cleared or held clear per REQ-019.
REQ-014 All next-state decisions SHALL use the registered pending value, never raw buttons (one-cycle request latency).
REQ-015 "Above" = any pending bit > floor; "below" = any pending bit < floor.
REQ-016 IDLE: if pending[floor] -> DOOR_OPEN; else if dir_up & above -> MOVE_UP; else if !dir_up & below -> MOVE_DOWN; else if above -> MOVE_UP, dir_up<=1; else if below -> MOVE_DOWN, dir_up<=0; else stay IDLE.
REQ-017 MOVE_UP: travel timer counts MOVE_CYCLES; on expiry floor<=floor+1, then: pending[floor+1] -> DOOR_OPEN; else requests above floor+1 -> remain MOVE_UP; else -> IDLE.
REQ-018 MOVE_DOWN: mirror of REQ-017 with floor-1 and "below".
REQ-019 Entering DOOR_OPEN clears pending[target floor]; while in DOOR_OPEN, pending[floor] held 0 (presses of the current floor absorbed).
REQ-020 DOOR_OPEN lasts exactly DOOR_CYCLES cycles, then -> IDLE; floor and dir_up unchanged.
REQ-021 floor SHALL never leave 0..4: no MOVE_UP from 4, no MOVE_DOWN from 0.
REQ-022 Requests arriving during travel SHALL be served in the same sweep if still ahead of the car; requests behind the car wait for reversal (SCAN).
REQ-023 Simultaneous presses of several floors SHALL all latch in the same edge.

Reset
REQ-024 While rst_n=0 at an edge: state IDLE, floor=0, dir_up=1, moving=0, door_open=0, pending=0, timers 0.
REQ-025 Reset SHALL take priority over any press or motion, including mid-travel and door-open (car jumps to floor 0, requests discarded).
REQ-026 Before first reset, outputs are don't-care; the bench SHALL apply reset first.

Verification
REQ-027 Reset, then buttons=5'b10000 for one cycle (edge E1) -> pending[4]=1 at E1, MOVE_UP at E2, floor 1,2,3,4 at E3..E6, door_open=1 at E6..E7, pending=0, IDLE at E8.
REQ-028 Car idle at floor 0, press floor 0 -> door_open next cycle after latch, floor stays 0, DOOR_CYCLES cycles open.
REQ-029 Car moving up from 0 toward 4, press floor 2 before car passes 2 -> stops at 2 (door opens), then continues to 4.
REQ-030 At floor 4 with door open, floors 1 and 0 pressed -> MOVE_DOWN, dir_up=0, stops at 1 then 0.
REQ-031 Car at floor 3 with dir_up=1, requests at 1 and 4 pending -> serves 4 first, then reverses to 1.
REQ-032 Assert rst_n=0 while moving between floors -> next edge floor=0, IDLE, pending=0, moving=0.

Source files
------------

// File: rtl/elevator.sv
// Five-floor SCAN elevator controller; registered outputs, requests act one cycle after the press.
// No backpressure: buttons are level-sampled every edge and latched into pending until served.
module elevator #(
   parameter int MOVE_CYCLES = 1,
   parameter int DOOR_CYCLES = 2
) (
   input  logic [4:0] buttons,
   input  logic       clk,
   input  logic       rst_n,
   output logic [2:0] floor,
   output logic       dir_up,
   output logic       moving,
   output logic       door_open,
   output logic [4:0] pending
);

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

   localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    floor_n, fu, fd;
   logic          dir_n;
   logic [4:0]    clr, pending_n;
   logic          move_last, door_last;

   function automatic logic any_above(input logic [4:0] p, input logic [2:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 5; i++)
         if (p[i] && (3'(i) > f)) r = 1'b1;
      return r;
   endfunction

   function automatic logic any_below(input logic [4:0] p, input logic [2:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 5; i++)
         if (p[i] && (3'(i) < f)) r = 1'b1;
      return r;
   endfunction

   assign fu        = floor + 3'd1;
   assign fd        = floor - 3'd1;
   assign move_last = (timer == TW'(MOVE_CYCLES - 1));
   assign door_last = (timer == TW'(DOOR_CYCLES - 1));

   always_comb begin
      state_n = state;
      timer_n = timer;
      floor_n = floor;
      dir_n   = dir_up;
      clr     = 5'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (pending[floor]) begin
               state_n    = DOOR_OPEN;
               clr[floor] = 1'b1;
            end else if (dir_up && any_above(pending, floor)) begin
               state_n = MOVE_UP;
            end else if (!dir_up && any_below(pending, floor)) begin
               state_n = MOVE_DOWN;
            end else if (any_above(pending, floor)) begin
               state_n = MOVE_UP;
               dir_n   = 1'b1;
            end else if (any_below(pending, floor)) begin
               state_n = MOVE_DOWN;
               dir_n   = 1'b0;
            end
         end
         MOVE_UP: begin
            // Top floor guard keeps floor inside 0..4 even if state were corrupted.
            if (floor == 3'd4) begin
               state_n = IDLE;
               timer_n = '0;
            end else if (move_last) begin
               timer_n = '0;
               floor_n = fu;
               if (pending[fu]) begin
                  state_n = DOOR_OPEN;
                  clr[fu] = 1'b1;
               end else if (!any_above(pending, fu)) begin
                  state_n = IDLE;
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         MOVE_DOWN: begin
            if (floor == 3'd0) begin
               state_n = IDLE;
               timer_n = '0;
            end else if (move_last) begin
               timer_n = '0;
               floor_n = fd;
               if (pending[fd]) begin
                  state_n = DOOR_OPEN;
                  clr[fd] = 1'b1;
               end else if (!any_below(pending, fd)) begin
                  state_n = IDLE;
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            // Presses of the floor the car is standing at are absorbed while open.
            clr[floor] = 1'b1;
            if (door_last) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
      endcase
      pending_n = (pending | buttons) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         floor     <= 3'd0;
         dir_up    <= 1'b1;
         moving    <= 1'b0;
         door_open <= 1'b0;
         pending   <= 5'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         floor     <= floor_n;
         dir_up    <= dir_n;
         moving    <= (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
         door_open <= (state_n == DOOR_OPEN);
         pending   <= pending_n;
      end
   end

endmodule

// File: tb/tb_elevator.sv
// Directed-vector scoreboard bench for the elevator: expectations queued per edge, checked by a monitor.
module tb_elevator;

   logic       clk;
   logic       rst_n;
   logic [4:0] buttons;
   logic [2:0] floor;
   logic       dir_up, moving, door_open;
   logic [4:0] pending;

   typedef struct packed {
      int         tag;
      logic [2:0] fl;
      logic       dir;
      logic       mov;
      logic       door;
      logic [4:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   ntag = 0;

   elevator #(.MOVE_CYCLES(1), .DOOR_CYCLES(2)) dut (
      .buttons  (buttons),
      .clk      (clk),
      .rst_n    (rst_n),
      .floor    (floor),
      .dir_up   (dir_up),
      .moving   (moving),
      .door_open(door_open),
      .pending  (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change on the falling edge; the expected state after the next rising edge is queued.
   task automatic step(input logic r, input logic [4:0] b, input logic [2:0] f,
                       input logic d, input logic m, input logic o, input logic [4:0] p);
      exp_t e;
      @(negedge clk);
      rst_n   = r;
      buttons = b;
      e.tag  = ntag;
      e.fl   = f;
      e.dir  = d;
      e.mov  = m;
      e.door = o;
      e.pend = p;
      exp_q.push_back(e);
      ntag++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nvec++;
            if (floor !== e.fl || dir_up !== e.dir || moving !== e.mov ||
                door_open !== e.door || pending !== e.pend) begin
               nerr++;
               $display("FAIL vec%0d: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, want floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
                        e.tag, floor, dir_up, moving, door_open, pending,
                        e.fl, e.dir, e.mov, e.door, e.pend);
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      rst_n   = 1'b0;
      buttons = 5'b0;

      // reset, then a single press of floor 4 from floor 0
      step(1'b0, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00000);
      step(1'b0, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00000);
      step(1'b1, 5'b10000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd0, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd1, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd3, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0, 5'b00000);
      // reset while parked at 4 returns the car to floor 0
      step(1'b0, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00000);

      // press the current floor; a repeat press while open is absorbed
      step(1'b1, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00001);
      step(1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 0, 5'b00000);

      // going to 4, floor 2 pressed en route; at 4 floors 1 and 0 pressed
      step(1'b1, 5'b10000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b10000);
      step(1'b1, 5'b00100, 3'd0, 1'b1, 1'b1, 1'b0, 5'b10100);
      step(1'b1, 5'b00000, 3'd1, 1'b1, 1'b1, 1'b0, 5'b10100);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b1, 5'b10000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b1, 5'b10000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00000, 3'd3, 1'b1, 1'b1, 1'b0, 5'b10000);
      step(1'b1, 5'b00011, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00011);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00011);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0, 5'b00011);
      step(1'b1, 5'b00000, 3'd4, 1'b0, 1'b1, 1'b0, 5'b00011);
      step(1'b1, 5'b00000, 3'd3, 1'b0, 1'b1, 1'b0, 5'b00011);
      step(1'b1, 5'b00000, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00011);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b1, 5'b00001);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b1, 5'b00001);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0, 5'b00001);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b1, 1'b0, 5'b00001);
      step(1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000);

      // from 0 heading down-biased: go to 3, then with 1 and 4 pending serve 4 first
      step(1'b1, 5'b01000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b01000);
      step(1'b1, 5'b00000, 3'd0, 1'b1, 1'b1, 1'b0, 5'b01000);
      step(1'b1, 5'b00000, 3'd1, 1'b1, 1'b1, 1'b0, 5'b01000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b1, 1'b0, 5'b01000);
      step(1'b1, 5'b00000, 3'd3, 1'b1, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b10010, 3'd3, 1'b1, 1'b0, 1'b1, 5'b10010);
      step(1'b1, 5'b00000, 3'd3, 1'b1, 1'b0, 1'b0, 5'b10010);
      step(1'b1, 5'b00000, 3'd3, 1'b1, 1'b1, 1'b0, 5'b10010);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00010);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00010);
      step(1'b1, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0, 5'b00010);
      step(1'b1, 5'b00000, 3'd4, 1'b0, 1'b1, 1'b0, 5'b00010);
      step(1'b1, 5'b00000, 3'd3, 1'b0, 1'b1, 1'b0, 5'b00010);
      step(1'b1, 5'b00000, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00010);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b1, 5'b00000);
      step(1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0, 5'b00000);

      // two floors latched together, then reset mid-travel beats a new press
      step(1'b1, 5'b11000, 3'd1, 1'b0, 1'b0, 1'b0, 5'b11000);
      step(1'b1, 5'b00000, 3'd1, 1'b1, 1'b1, 1'b0, 5'b11000);
      step(1'b1, 5'b00000, 3'd2, 1'b1, 1'b1, 1'b0, 5'b11000);
      step(1'b0, 5'b00100, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00000);
      step(1'b1, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00000);

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (exp_q.size() > 0) begin
         nerr++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
